bin_frame_streamer: RTL
=======================

# bin_frame_streamer

Downstream neighbour of the binning stage: captures the 28x28 grayscale frame that binning writes through its `addr`/`wdata`/`wr_en` SRAM-style port and, once binning signals `bin_done`, replays the 784 pixels in raster order on an 8-bit AXI-Stream master toward the k-means datapath. The block owns the frame buffer, an inferred single-clock BRAM of 784 x 8 bits. It replaces the testbench-side SRAM model in the integrated design.

## Interface
- `IMG_W`, default 28, frame width in pixels.
- `IMG_H`, default 28, frame height in pixels.
- `PIX_W`, default 8, stored and streamed pixel width.
- `clk` input, 1 bit: sole clock.
- `reset` input, 1 bit: synchronous, active-high reset.
- `wr_en` input, 1 bit: write strobe from binning.
- `addr` input, 32 bits: byte address from binning. Pixel index = `addr[31:2]`.
- `wdata` input, 32 bits: write data. Only `wdata[PIX_W-1:0]` is stored.
- `bin_done` input, 1 bit: level from binning. Its rising edge closes the frame.
- `m_axis_tdata` output, `PIX_W` bits: pixel out.
- `m_axis_tvalid` output, 1 bit: output beat valid.
- `m_axis_tready` input, 1 bit: downstream ready.
- `m_axis_tlast` output, 1 bit: high on pixel `IMG_W*IMG_H-1`.
- `busy` output, 1 bit: high while in STREAM.
- `frame_count` output, 16 bits: number of frames fully streamed (stats).
- `err_flags` output, 3 bits: sticky flags `{short_frame, addr_err, overrun_err}` (stats).

## Operation
- State machine has two states: FILL and STREAM. Reset state is FILL.
- FILL
  - A cycle with `wr_en=1` and index < 784 writes `wdata[7:0]` to `mem[index]` and increments `wr_cnt`, a 10-bit counter saturating at 784.
  - Index >= 784: the write is dropped and `addr_err` is set.
  - `bin_done` is registered internally. A rising edge (registered value 0, current value 1) moves the state to STREAM on the next edge.
  - On that transition `short_frame` is set if `wr_cnt` < 784, and `wr_cnt` clears.
  - A write in the same cycle as the `bin_done` rising edge is stored and belongs to the closing frame.
- STREAM
  - `rd_idx` runs from 0 to 783. Pixel `rd_idx` is presented on `m_axis_tdata`.
  - A beat is transferred when `tvalid & tready`. On each transfer `rd_idx` increments.
  - The transfer at `rd_idx`=783 (with `tlast=1`) returns the state to FILL, drops `tvalid` the next cycle and increments `frame_count` (wraps at 65535 to 0).
  - Any `wr_en` during STREAM is dropped and sets `overrun_err`.
  - A `bin_done` rising edge during STREAM is ignored.
- Memory contents are never cleared. Pixels not rewritten in a frame replay their previous-frame value.
- `err_flags` bits stay set until reset.

## Timing
- Values at reset: state FILL, `m_axis_tvalid`=0, `m_axis_tlast`=0, `m_axis_tdata`=0, `busy`=0, `frame_count`=0, `err_flags`=0, `rd_idx`=0, `wr_cnt`=0.
- Memory read is synchronous with a 1-cycle read latency.
- Latency: with the `bin_done` rising edge sampled at edge E, `busy`=1 after E+1 and the first beat (pixel 0) is valid after E+2.
- Throughput: the read address is `rd_idx+1` on a transfer cycle and `rd_idx` otherwise. With `tready` held high, one beat per cycle; 784 beats take 784 consecutive cycles.
- AXI rules:
  - `tdata` and `tlast` stay stable while `tvalid & !tready`.
  - `tvalid` never drops without a transfer, except on reset.
  - `tvalid` does not depend combinationally on `tready`.
- Reset mid-STREAM: the frame is aborted with no `tlast` and `frame_count` is unchanged. After reset the block waits in FILL for a new `bin_done` rising edge.
- `bin_done` held high across a return to FILL does not retrigger; a fresh 0-to-1 transition is required.

## Configuration
- `BIN_STREAM_STATS_EN` defined:
  - `frame_count` and `err_flags` logic is present as described above.
- `BIN_STREAM_STATS_EN` undefined:
  - `frame_count` is tied to 16'd0 and `err_flags` to 3'b000.
  - The counters and sticky flags are not synthesized.
  - Write drop rules and state behaviour are unchanged.

## Test plan
- **Full frame:** write `mem[i]=i[7:0]` at `addr=4*i` for i=0..783, pulse `bin_done`, `tready`=1 → beats 0..783 appear with `tdata=i[7:0]` on consecutive cycles, `tlast` only on beat 783, first beat 2 cycles after the edge, `frame_count`=1, `err_flags`=0.
- **Backpressure:** same frame, `tready` random at 50% → the 784 beats arrive in order, `tdata`/`tlast` are stable during stalls, there is no extra or missing beat, and the final transfer returns `busy` to 0.
- **Bad writes:** write `addr=4*784` and `addr=4*1000` in FILL → memory is unchanged and `err_flags`=3'b010. A write during STREAM is dropped and sets `err_flags[0]`.
- **Short frame:** write 500 pixels, then raise `bin_done` → `err_flags[2]`=1. The stream still emits 784 beats, and pixels 500..783 hold their previous-frame values.
- **Reset mid-stream:** assert `reset` at beat 300 → `tvalid`=0 after the edge and `frame_count`=0. A new frame plus a `bin_done` edge streams from pixel 0.
- **Back-to-back frames:** hold `bin_done` high through the end of frame 1 → no restart. Drop it, run a second fill and raise it → second stream, `frame_count`=2.

Source files
------------

// File: rtl/bin_frame_streamer.sv
// Frame buffer between binning and k-means: captures IMG_W x IMG_H pixels, replays them on AXI-Stream.
// Optional stats (frame_count, err_flags) are built only when BIN_STREAM_STATS_EN is defined.
module bin_frame_streamer #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int PIX_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [31:0]      addr,
  input  logic [31:0]      wdata,
  input  logic             bin_done,
  output logic [PIX_W-1:0] m_axis_tdata,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic             m_axis_tlast,
  output logic             busy,
  output logic [15:0]      frame_count,
  output logic [2:0]       err_flags
);
  // state  | meaning
  // FILL   | accept pixel writes, wait for a bin_done rise
  // STREAM | replay the frame in raster order, writes are dropped
  localparam int DEPTH = IMG_W * IMG_H;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  typedef enum logic {FILL, STREAM} state_t;

  state_t           state_q, state_d;
  logic             bin_done_q, bin_rise_q;
  logic [AW-1:0]    rd_idx, rd_idx_d, rd_addr;
  logic [PIX_W-1:0] rdata;
  logic             tvalid_q, tvalid_d;
  logic [29:0]      pix_idx;
  logic             wr_in_range, wr_ok, xfer, last_xfer, frame_close;
  logic             unused_bits;

  logic [PIX_W-1:0] mem [DEPTH];

  assign pix_idx     = addr[31:2];
  assign wr_in_range = pix_idx < 30'(DEPTH);
  assign xfer        = tvalid_q & m_axis_tready;
  assign last_xfer   = xfer & (rd_idx == LAST_IDX);
  assign frame_close = (state_q == FILL) & bin_rise_q;
  assign unused_bits = ^{addr[1:0], wdata[31:PIX_W]};

  always_ff @(posedge clk) begin
    if (reset) state_q <= FILL;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL:    if (bin_rise_q) state_d = STREAM;
      STREAM:  if (last_xfer)  state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  always_comb begin
    busy     = (state_q == STREAM);
    wr_ok    = (state_q == FILL) & wr_en & wr_in_range;
    tvalid_d = (state_q == STREAM) & ~last_xfer;
    rd_idx_d = last_xfer ? '0 : rd_idx + AW'(1);
    rd_addr  = xfer ? rd_idx_d : rd_idx;
  end

  // bin_done_q resets high so a level already asserted at reset never counts as a new rise;
  // rises seen while streaming are discarded rather than queued.
  always_ff @(posedge clk) begin
    if (reset) begin
      bin_done_q <= 1'b1;
      bin_rise_q <= 1'b0;
    end else begin
      bin_done_q <= bin_done;
      bin_rise_q <= bin_done & ~bin_done_q & (state_q == FILL);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[pix_idx[AW-1:0]] <= wdata[PIX_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) rdata <= '0;
    else       rdata <= mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_idx   <= '0;
      tvalid_q <= 1'b0;
    end else begin
      tvalid_q <= tvalid_d;
      if (xfer) rd_idx <= rd_idx_d;
    end
  end

  assign m_axis_tdata  = rdata;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tvalid_q & (rd_idx == LAST_IDX);

`ifdef BIN_STREAM_STATS_EN
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

  logic [CW-1:0] wr_cnt;
  logic [CW:0]   fill_total;
  logic [15:0]   frame_cnt_q;
  logic          short_q, addr_err_q, overrun_q;

  // A write landing in the closing cycle still belongs to the frame being closed.
  assign fill_total = {1'b0, wr_cnt} + {{CW{1'b0}}, wr_ok};

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_cnt      <= '0;
      frame_cnt_q <= '0;
      short_q     <= 1'b0;
      addr_err_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      if (frame_close)                   wr_cnt <= '0;
      else if (wr_ok && wr_cnt != CNT_MAX) wr_cnt <= wr_cnt + CW'(1);
      if (last_xfer) frame_cnt_q <= frame_cnt_q + 16'd1;
      if (frame_close && fill_total < (CW+1)'(DEPTH)) short_q <= 1'b1;
      if ((state_q == FILL) && wr_en && !wr_in_range) addr_err_q <= 1'b1;
      if ((state_q == STREAM) && wr_en) overrun_q <= 1'b1;
    end
  end

  assign frame_count = frame_cnt_q;
  assign err_flags   = {short_q, addr_err_q, overrun_q};
`else
  assign frame_count = 16'd0;
  assign err_flags   = 3'b000;
`endif

endmodule
